// File: rtl/cim_pkg.sv
// Shared types and helpers for the CIM crossbar tile model.
package cim_pkg;

  typedef enum logic [1:0] {CIM_IDLE, CIM_COMPUTE, CIM_COMMIT} cim_state_t;

  function automatic int unsigned acc_width(input int unsigned xs, input int unsigned ds);
    return ds + $clog2(xs);
  endfunction

  // Clip an unsigned accumulator to the largest value representable in ds bits.
  function automatic logic [31:0] sat_trunc(input logic [31:0] acc, input int unsigned ds);
    logic [31:0] max_val;
    max_val = (32'd1 << ds) - 32'd1;
    return (acc > max_val) ? max_val : acc;
  endfunction

endpackage

// File: rtl/cim_xbar_model_if.sv
// CIM write/read bus between an fc_layer (master) and one crossbar tile (slave).
interface cim_xbar_model_if #(
  parameter int unsigned xbar_size     = 256,
  parameter int unsigned datatype_size = 2
);
  localparam int unsigned aw = $clog2(xbar_size);

  logic                     i_w_we;
  logic [aw-1:0]            i_w_row;
  logic [xbar_size-1:0]     i_w_data;
  logic                     i_we;
  logic [aw-1:0]            i_wr_addr;
  logic [datatype_size-1:0] i_wr_data;
  logic                     i_exec;
  logic                     o_busy;
  logic [aw-1:0]            i_rd_addr;
  logic [datatype_size-1:0] o_rd_data;

  modport master (
    output i_w_we, i_w_row, i_w_data, i_we, i_wr_addr, i_wr_data, i_exec, i_rd_addr,
    input  o_busy, o_rd_data
  );

  modport slave (
    input  i_w_we, i_w_row, i_w_data, i_we, i_wr_addr, i_wr_data, i_exec, i_rd_addr,
    output o_busy, o_rd_data
  );

endinterface

// File: rtl/cim_weight_mem.sv
// Binary weight array: one row-wide write port, one combinational row read port.
module cim_weight_mem #(
  parameter int unsigned xbar_size = 256
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [$clog2(xbar_size)-1:0] wr_row,
  input  logic [xbar_size-1:0]         wr_data,
  input  logic [$clog2(xbar_size)-1:0] rd_row,
  output logic [xbar_size-1:0]         rd_data
);

  // Deliberately unreset so the array can map onto RAM.
  logic [xbar_size-1:0] mem [xbar_size];

  always_ff @(posedge clk) begin
    if (we) mem[wr_row] <= wr_data;
  end

  assign rd_data = mem[rd_row];

endmodule

// File: rtl/cim_xbar_model.sv
// CIM crossbar tile: input register, row-serial saturated MVM, registered result read port.
module cim_xbar_model
  import cim_pkg::*;
#(
  parameter int unsigned xbar_size     = 256,
  parameter int unsigned datatype_size = 2
) (
  input logic            clk,
  input logic            rst,
  cim_xbar_model_if.slave bus
);

  localparam int unsigned aw       = $clog2(xbar_size);
  localparam int unsigned acc_size = acc_width(xbar_size, datatype_size);
  localparam logic [aw-1:0] last_row = aw'(xbar_size - 1);

  cim_state_t               state_q;
  logic                     busy_q;
  logic [aw-1:0]            row_q;
  logic [datatype_size-1:0] rd_q;
  logic [datatype_size-1:0] in_q  [xbar_size];
  logic [acc_size-1:0]      acc_q [xbar_size];
  logic [datatype_size-1:0] res_q [xbar_size];
  logic [datatype_size-1:0] res_sat [xbar_size];
  logic [xbar_size-1:0]     w_row;
  logic [acc_size-1:0]      in_ext;

  cim_weight_mem #(
    .xbar_size(xbar_size)
  ) u_weight_mem (
    .clk    (clk),
    .we     (bus.i_w_we && (state_q == CIM_IDLE)),
    .wr_row (bus.i_w_row),
    .wr_data(bus.i_w_data),
    .rd_row (row_q),
    .rd_data(w_row)
  );

  assign in_ext = acc_size'(in_q[row_q]);

  always_comb begin
    for (int c = 0; c < int'(xbar_size); c++) begin
      res_sat[c] = datatype_size'(sat_trunc(32'(acc_q[c]), datatype_size));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CIM_IDLE;
      busy_q  <= 1'b0;
      row_q   <= '0;
      rd_q    <= '0;
      for (int c = 0; c < int'(xbar_size); c++) begin
        in_q[c]  <= '0;
        acc_q[c] <= '0;
        res_q[c] <= '0;
      end
    end else begin
      rd_q <= res_q[bus.i_rd_addr];
      unique case (state_q)
        CIM_IDLE: begin
          // The input write lands before COMPUTE first reads in_q, so exec sees it.
          if (bus.i_we) in_q[bus.i_wr_addr] <= bus.i_wr_data;
          if (bus.i_exec) begin
            state_q <= CIM_COMPUTE;
            busy_q  <= 1'b1;
            row_q   <= '0;
            for (int c = 0; c < int'(xbar_size); c++) acc_q[c] <= '0;
          end
        end
        CIM_COMPUTE: begin
          for (int c = 0; c < int'(xbar_size); c++) begin
            if (w_row[c]) acc_q[c] <= acc_q[c] + in_ext;
          end
          row_q <= row_q + aw'(1);
          if (row_q == last_row) state_q <= CIM_COMMIT;
        end
        CIM_COMMIT: begin
          for (int c = 0; c < int'(xbar_size); c++) res_q[c] <= res_sat[c];
          busy_q  <= 1'b0;
          state_q <= CIM_IDLE;
        end
        default: state_q <= CIM_IDLE;
      endcase
    end
  end

  assign bus.o_busy    = busy_q;
  assign bus.o_rd_data = rd_q;

endmodule

// File: tb/tb_cim_xbar_model.sv
// Self-checking bench for cim_xbar_model with an 8x8 crossbar and 2-bit data.
module tb_cim_xbar_model;

  localparam int unsigned Xs = 8;
  localparam int unsigned Ds = 2;

  typedef struct {
    string       name;
    logic [63:0] w;    // row r at bits [8r+7:8r]
    logic [15:0] in;   // element r at bits [2r+1:2r]
    logic [15:0] exp;  // column c at bits [2c+1:2c]
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  logic [7:0] w_m   [8];
  int         in_m  [8];
  int         res_m [8];

  cim_xbar_model_if #(.xbar_size(Xs), .datatype_size(Ds)) bus ();

  cim_xbar_model #(
    .xbar_size    (Xs),
    .datatype_size(Ds)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  function automatic void model_exec();
    for (int c = 0; c < 8; c++) begin
      int s = 0;
      for (int r = 0; r < 8; r++) if (w_m[r][c]) s += in_m[r];
      res_m[c] = (s > 3) ? 3 : s;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wr_in(input int a, input int d);
    logic [2:0] av;
    logic [1:0] dv;
    av = 3'(a);
    dv = 2'(d);
    bus.i_we = 1'b1; bus.i_wr_addr = av; bus.i_wr_data = dv;
    tick();
    bus.i_we = 1'b0;
    in_m[a] = d;
  endtask

  task automatic wr_w(input int r, input logic [7:0] d);
    logic [2:0] rv;
    rv = 3'(r);
    bus.i_w_we = 1'b1; bus.i_w_row = rv; bus.i_w_data = d;
    tick();
    bus.i_w_we = 1'b0;
    w_m[r] = d;
  endtask

  task automatic exec_start();
    bus.i_exec = 1'b1;
    tick();
    bus.i_exec = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.o_busy && n < 100) begin
      n++;
      tick();
    end
  endtask

  task automatic read_col(input int c, output int v);
    bus.i_rd_addr = 3'(c);
    tick();
    v = int'(bus.o_rd_data);
  endtask

  task automatic check_all_model(input string tag);
    int v;
    for (int c = 0; c < 8; c++) begin
      read_col(c, v);
      check($sformatf("%s col%0d", tag, c), v, res_m[c]);
    end
  endtask

  task automatic run_exec(input string tag);
    int n;
    exec_start();
    wait_idle(n);
    check({tag, " busy cycles"}, n, 9);
    model_exec();
  endtask

  vec_t tbl[6];

  initial begin
    int v, n, old_v, new_v, bad;

    tbl[0] = '{"identity",    64'h8040201008040201, 16'h1BE4, 16'h1BE4};
    tbl[1] = '{"sat_all1",    64'hFFFFFFFFFFFFFFFF, 16'h5555, 16'hFFFF};
    tbl[2] = '{"sat_in0_2",   64'hFFFFFFFFFFFFFFFF, 16'h0002, 16'hAAAA};
    tbl[3] = '{"zero_w",      64'h0000000000000000, 16'hFFFF, 16'h0000};
    tbl[4] = '{"anti_diag",   64'h0102040810204080, 16'h0039, 16'h6C00};
    tbl[5] = '{"two_rows",    64'h0000000000000F0F, 16'h0005, 16'h00AA};

    bus.i_w_we = 1'b0; bus.i_w_row = '0; bus.i_w_data = '0;
    bus.i_we = 1'b0; bus.i_wr_addr = '0; bus.i_wr_data = '0;
    bus.i_exec = 1'b0; bus.i_rd_addr = '0;
    for (int i = 0; i < 8; i++) begin
      in_m[i] = 0; res_m[i] = 0; w_m[i] = '0;
    end

    // Reset release
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("reset busy", int'(bus.o_busy), 0);
    check_all_model("reset");

    // Table-driven vectors
    for (int t = 0; t < 6; t++) begin
      for (int r = 0; r < 8; r++) begin
        wr_w(r, tbl[t].w[8*r +: 8]);
        wr_in(r, int'(tbl[t].in[2*r +: 2]));
      end
      run_exec(tbl[t].name);
      for (int c = 0; c < 8; c++) begin
        read_col(c, v);
        check($sformatf("%s col%0d", tbl[t].name, c), v, int'(tbl[t].exp[2*c +: 2]));
      end
    end

    // Busy lockout: writes and exec during COMPUTE are dropped
    for (int r = 0; r < 8; r++) wr_w(r, 8'(1 << r));
    for (int r = 0; r < 8; r++) wr_in(r, (r < 4) ? r : 7 - r);
    exec_start();
    tick();
    bus.i_we = 1'b1; bus.i_wr_addr = 3'd0; bus.i_wr_data = 2'd3;
    bus.i_w_we = 1'b1; bus.i_w_row = 3'd0; bus.i_w_data = 8'hFF;
    bus.i_exec = 1'b1;
    tick();
    bus.i_we = 1'b0; bus.i_w_we = 1'b0; bus.i_exec = 1'b0;
    wait_idle(n);
    check("lockout remaining busy", n, 7);
    model_exec();
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.o_busy) bad++;
    end
    check("lockout no second busy", bad, 0);
    check_all_model("lockout");
    run_exec("lockout rerun");
    check_all_model("lockout rerun");

    // Same-cycle write + exec, and read during COMMIT
    old_v = res_m[1];
    bus.i_rd_addr = 3'd1;
    bus.i_we = 1'b1; bus.i_wr_addr = 3'd1; bus.i_wr_data = 2'd2;
    bus.i_exec = 1'b1;
    tick();
    bus.i_we = 1'b0; bus.i_exec = 1'b0;
    in_m[1] = 2;
    model_exec();
    new_v = res_m[1];
    repeat (8) tick();
    check("commit busy", int'(bus.o_busy), 1);
    tick();
    check("commit read old", int'(bus.o_rd_data), old_v);
    check("post commit busy", int'(bus.o_busy), 0);
    tick();
    check("commit read new", int'(bus.o_rd_data), new_v);
    check_all_model("same cycle");

    // Reset mid-compute; weights survive
    exec_start();
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midreset busy", int'(bus.o_busy), 0);
    for (int i = 0; i < 8; i++) begin
      in_m[i] = 0; res_m[i] = 0;
    end
    check_all_model("midreset");
    for (int r = 0; r < 8; r++) wr_in(r, (r % 3) + 1);
    run_exec("retained");
    check_all_model("retained");

    // Randomized writes checked against the reference model
    for (int it = 0; it < 10; it++) begin
      int k = $urandom_range(1, 8);
      for (int j = 0; j < k; j++) begin
        if ($urandom_range(0, 1) == 0) wr_w($urandom_range(0, 7), 8'($urandom));
        else wr_in($urandom_range(0, 7), $urandom_range(0, 3));
      end
      run_exec($sformatf("rand%0d", it));
      check_all_model($sformatf("rand%0d", it));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cim_xbar_model.md
Name: cim_xbar_model

Overview:
- Cycle-level behavioural model of one CIM crossbar tile: the responder on the far side of an fc_layer's CIM write/read interface.
- Holds a binary weight array and an input vector register.
- On exec it computes a saturated per-column dot product, one row per cycle.
- Results are exposed through a registered read port. fc_layer tiles are instantiated v_cim_tiles x h_cim_tiles times around each layer in the MLP tops.

Parameters:
- xbar_size, 256, rows = columns of the crossbar; power of two, >= 4.
- datatype_size, 2, width of input elements and of each column result.
- acc_size, datatype_size + $clog2(xbar_size), internal accumulator width (derived; do not override).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- i_w_we  input  1  weight write strobe
- i_w_row  input  $clog2(xbar_size)  weight row address
- i_w_data  input  xbar_size  full weight row, bit c = cell (row, c)
- i_we  input  1  input-register write strobe
- i_wr_addr  input  $clog2(xbar_size)  input element index (row)
- i_wr_data  input  datatype_size  input element value, unsigned
- i_exec  input  1  start one matrix-vector multiply
- o_busy  output  1  high from the cycle after accepted exec until the results are committed
- i_rd_addr  input  $clog2(xbar_size)  result column index
- o_rd_data  output  datatype_size  result of column i_rd_addr, registered

Behaviour:
- Reset (synchronous, active-high, clk is the only clock):
  - o_busy=0, o_rd_data=0, FSM=IDLE.
  - Input register, all result entries and row counter cleared to 0.
  - Weight array is NOT reset; its contents are undefined until written.
- FSM states:
  - IDLE: i_exec=1 -> COMPUTE; row counter=0, accumulators cleared; o_busy=1 from the next cycle.
  - COMPUTE: each cycle, for every column c: acc[c] += w[row][c] ? in[row] : 0; row++. After row xbar_size-1 is processed -> COMMIT.
  - COMMIT (1 cycle): result[c] = (acc[c] > 2^datatype_size-1) ? 2^datatype_size-1 : acc[c][datatype_size-1:0] (saturate). -> IDLE, o_busy=0 in the cycle after COMMIT.
- Exec latency: the exec edge is cycle 0. o_busy is high for cycles 1..xbar_size+1, i.e. xbar_size+1 cycles. New results are readable from cycle xbar_size+2.
- Accumulator is acc_size bits, unsigned; it cannot overflow (max (2^d-1)*xbar_size).
- Writes in IDLE:
  - i_we in IDLE writes in[i_wr_addr] <= i_wr_data.
  - i_w_we in IDLE writes w[i_w_row] <= i_w_data.
  - A write and i_exec in the same IDLE cycle: the write lands first, and the computation uses the updated value.
- Writes while busy (COMPUTE or COMMIT): i_we, i_w_we and i_exec are ignored, with no queueing. The operand snapshot is the state at the exec cycle.
- Read port: o_rd_data <= result[i_rd_addr] every cycle, 1-cycle latency, in any state. While busy, reads return the previous results. The result buffer changes only in COMMIT.
- Reading the same column in the COMMIT cycle returns the old value; the new value appears one cycle later.
- Reset mid-COMPUTE aborts the operation: FSM=IDLE, o_busy=0, results=0. Weights are retained.

Decomposition:
- Shared package cim_pkg:
  - typedef enum {CIM_IDLE, CIM_COMPUTE, CIM_COMMIT} cim_state_t;
  - function sat_trunc(acc, datatype_size).
  - constant function for the acc_size derivation.
- One sub-module, cim_weight_mem:
  - xbar_size x xbar_size-bit row memory.
  - One write port (row) and one combinational read port (row = row counter).
  - No reset, so it can map to RAM.
- Top holds the FSM, the input register, the accumulator array and the result buffer.

Test Plan (xbar_size=8, datatype_size=2 unless noted):
- Reset release: rst high 2 cycles, then read all 8 columns -> o_rd_data=0 each, o_busy=0.
- Identity weights (w[r]=1<<r), in=[0,1,2,3,3,2,1,0], exec -> o_busy high exactly 9 cycles; afterwards reads of columns 0..7 return 0,1,2,3,3,2,1,0.
- Saturation: all weights 8'hFF, in all 1, exec -> every column result is 3 (acc=8 clipped). Then in all 0 except in[0]=2, exec -> every column = 2.
- Busy lockout: during COMPUTE, pulse i_we (addr 0, data 3), i_w_we and i_exec -> result matches the exec-time snapshot; in[0] is unchanged; no second busy period follows.
- Same-cycle write+exec: in IDLE, assert i_we (addr 1, data 2) with i_exec, identity weights -> column 1 = 2. Also a read during COMMIT returns the old value, and the new value appears the next cycle.
- Reset mid-compute: assert rst at cycle 4 of COMPUTE -> o_busy=0 next cycle, all reads return 0; a subsequent exec without reloading weights returns results from the retained weights.
